// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, little-endian payload words written to
// program memory, trailing 8-bit checksum. Optional read-back verify via PROG_LOADER_VERIFY_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LEN    | collecting the 4-byte word count
// DATA   | collecting payload bytes of one word
// WRITE  | one-cycle memory write strobe
// VERIFY | read-back compare of the word just written (PROG_LOADER_VERIFY_EN only)
// CSUM   | waiting for the checksum byte
// DONE   | load finished, checksum good
// ERR    | load failed (length overflow, checksum or verify)
module prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 27,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] word_count
`ifdef PROG_LOADER_VERIFY_EN
    ,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`endif
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(BPW + 4);
    localparam logic [CNT_W-1:0] LAST_LEN  = CNT_W'(3);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BPW - 1);
    // Largest word count that still fits between BASE_ADDR and the top of memory.
    localparam logic [63:0] MAX_WORDS = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);

`ifdef PROG_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_VERIFY, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;
`endif

    state_t state, state_nx;

    logic [CNT_W-1:0]      byte_cnt;
    logic [31:0]           len_reg;
    logic [DATA_WIDTH-1:0] acc;
    logic [7:0]            csum;
    logic                  xfer;
    logic [31:0]           len_full;
    logic [DATA_WIDTH-1:0] word_full;
    logic                  count_reached;
`ifdef PROG_LOADER_VERIFY_EN
    logic                  last_word;
`endif

    assign xfer      = rx_valid & rx_ready;
    assign len_full  = {rx_data, len_reg[31:8]};
    // Bytes enter at the top and shift down, so the first byte ends in bits 7:0.
    assign word_full = (acc >> 8) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 8));
    assign count_reached = (64'(word_count) + 64'd1) == 64'(len_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        busy     = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LEN;
            end
            S_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && byte_cnt == LAST_LEN) begin
                    if (len_full == 32'd0)
                        state_nx = S_CSUM;
                    else if (64'(len_full) > MAX_WORDS)
                        state_nx = S_ERR;
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && byte_cnt == LAST_DATA) state_nx = S_WRITE;
            end
            S_WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
                state_nx = S_VERIFY;
`else
                state_nx = count_reached ? S_CSUM : S_DATA;
`endif
            end
`ifdef PROG_LOADER_VERIFY_EN
            S_VERIFY: begin
                busy = 1'b1;
                if (mem_rdata != mem_wdata)
                    state_nx = S_ERR;
                else
                    state_nx = last_word ? S_CSUM : S_DATA;
            end
`endif
            S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) state_nx = (rx_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_LEN;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nx = S_LEN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            len_reg    <= '0;
            acc        <= '0;
            csum       <= '0;
            word_count <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef PROG_LOADER_VERIFY_EN
            last_word  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        byte_cnt   <= '0;
                        len_reg    <= '0;
                        acc        <= '0;
                        csum       <= '0;
                        word_count <= '0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len_reg  <= len_full;
                        byte_cnt <= (byte_cnt == LAST_LEN) ? '0 : byte_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        acc  <= word_full;
                        csum <= csum + rx_data;
                        if (byte_cnt == LAST_DATA) begin
                            // Address and data are latched here so they hold after the strobe.
                            byte_cnt  <= '0;
                            mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + word_count;
                            mem_wdata <= word_full;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + ADDR_WIDTH'(1);
`ifdef PROG_LOADER_VERIFY_EN
                    last_word  <= count_reached;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: a default instance plus a small
// ADDR_WIDTH=4 / BASE_ADDR=10 instance for the length-overflow boundary.
`timescale 1ns/1ps
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        rx_ready, mem_we, busy, done, error;
    logic [26:0] mem_addr, word_count;
    logic [31:0] mem_wdata;

    logic        rx_ready2, mem_we2, busy2, done2, error2;
    logic [3:0]  mem_addr2, word_count2;
    logic [31:0] mem_wdata2;

    logic [31:0] mem_model [0:15];
    logic        corrupt = 1'b0;
    int          wr_cnt = 0;
    int          wr_cnt2 = 0;
    int          rdy_bad = 0;
    logic [26:0] log_addr [0:63];
    logic [31:0] log_data [0:63];

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

`ifdef PROG_LOADER_VERIFY_EN
    logic [31:0] mem_rdata;
    assign mem_rdata = mem_model[mem_addr[3:0]] ^ {31'b0, corrupt};
`endif

    prog_loader dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
`ifdef PROG_LOADER_VERIFY_EN
        , .mem_rdata(mem_rdata)
`endif
    );

    prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(10)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
        .busy(busy2), .done(done2), .error(error2), .word_count(word_count2)
`ifdef PROG_LOADER_VERIFY_EN
        , .mem_rdata(mem_wdata2)
`endif
    );

    // Memory model and write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] = mem_addr;
                log_data[wr_cnt] = mem_wdata;
            end
            mem_model[mem_addr[3:0]] <= mem_wdata;
            if (rx_ready) rdy_bad = rdy_bad + 1;
            wr_cnt = wr_cnt + 1;
        end
        if (mem_we2) wr_cnt2 = wr_cnt2 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic pulse_start(input bit which);
        if (which) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit which, input int gap);
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (which ? rx_ready2 : rx_ready) begin
                @(negedge clk);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_stream(input logic [7:0] bytes [$], input bit which, input int maxgap);
        foreach (bytes[i]) send(bytes[i], which, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    // Payload sum: 78+56+34+12+EF+BE+AD+DE = 0x44C, so the good checksum is 0x4C.
    logic [7:0] basic_good [$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    logic [7:0] basic_bad  [$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4D};
    logic [7:0] zero_len   [$] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] partial    [$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                   8'hEF, 8'hBE};
    logic [7:0] len6       [$] = '{8'h06, 8'h00, 8'h00, 8'h00};
    logic [7:0] len7       [$] = '{8'h07, 8'h00, 8'h00, 8'h00};

    task automatic check_basic(input string tag, input int base);
        chk({tag, "_we_count"}, 64'(wr_cnt - base), 64'd2);
        chk({tag, "_addr0"}, 64'(log_addr[base]), 64'd0);
        chk({tag, "_data0"}, 64'(log_data[base]), 64'h12345678);
        chk({tag, "_addr1"}, 64'(log_addr[base + 1]), 64'd1);
        chk({tag, "_data1"}, 64'(log_data[base + 1]), 64'hDEADBEEF);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wc"}, 64'(word_count), 64'd2);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);

        // Basic load
        base = wr_cnt;
        pulse_start(1'b0);
        chk("len_busy", 64'(busy), 64'd1);
        chk("len_ready", 64'(rx_ready), 64'd1);
        send_stream(basic_good, 1'b0, 0);
        check_basic("basic", base);

        // Bad checksum
        base = wr_cnt;
        pulse_start(1'b0);
        send_stream(basic_bad, 1'b0, 0);
        chk("badcs_we_count", 64'(wr_cnt - base), 64'd2);
        chk("badcs_error", 64'(error), 64'd1);
        chk("badcs_done", 64'(done), 64'd0);

        // Zero length
        base = wr_cnt;
        pulse_start(1'b0);
        send_stream(zero_len, 1'b0, 0);
        chk("zero_we_count", 64'(wr_cnt - base), 64'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_wc", 64'(word_count), 64'd0);

        // Stalls between bytes
        base = wr_cnt;
        pulse_start(1'b0);
        send_stream(basic_good, 1'b0, 10);
        check_basic("stall", base);
        chk("ready_during_write", 64'(rdy_bad), 64'd0);

        // Reset mid-load after the 6th payload byte, with start held alongside reset
        mem_model[0] = 32'h0;
        base = wr_cnt;
        pulse_start(1'b0);
        send_stream(partial, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rx_ready", 64'(rx_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wc", 64'(word_count), 64'd0);
        chk("midrst_addr", 64'(mem_addr), 64'd0);
        chk("midrst_wdata", 64'(mem_wdata), 64'd0);
        chk("midrst_flags", 64'({done, error, mem_we}), 64'd0);
        start = 1'b1;
        @(negedge clk);
        chk("start_with_reset_busy", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        chk("midrst_we_count", 64'(wr_cnt - base), 64'd1);
        chk("midrst_word0_kept", 64'(mem_model[0]), 64'h12345678);
        base = wr_cnt;
        pulse_start(1'b0);
        send_stream(basic_good, 1'b0, 0);
        check_basic("reload", base);

        // Length limit on the small instance: 16 - 10 = 6 words fit
        pulse_start(1'b1);
        send_stream(len6, 1'b1, 0);
        chk("len6_busy", 64'(busy2), 64'd1);
        chk("len6_error", 64'(error2), 64'd0);
        chk("len6_ready", 64'(rx_ready2), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse_start(1'b1);
        send_stream(len7, 1'b1, 0);
        chk("len7_error", 64'(error2), 64'd1);
        chk("len7_busy", 64'(busy2), 64'd0);
        chk("len7_no_we", 64'(wr_cnt2), 64'd0);

`ifdef PROG_LOADER_VERIFY_EN
        // Read-back mismatch on word 0
        corrupt = 1'b1;
        base = wr_cnt;
        pulse_start(1'b0);
        send_stream(basic_good[0:7], 1'b0, 0);
        repeat (4) @(negedge clk);
        chk("verify_error", 64'(error), 64'd1);
        chk("verify_busy", 64'(busy), 64'd0);
        chk("verify_we_count", 64'(wr_cnt - base), 64'd1);
        corrupt = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
